// File: rtl/aes_host_pkg.sv
// rtl/aes_host_pkg.sv - shared constants, encodings and helpers for the AES host driver
//
// Purpose: host address map, key-length encoding, key byte-count helper and
//          the driver FSM state type.
// Ports:   none (package).

package aes_host_pkg;

  // Host-side byte address map
  localparam logic [6:0] TEXT_BASE = 7'h00;
  localparam logic [6:0] KEY_BASE  = 7'h10;
  localparam logic [6:0] CFG_ADDR  = 7'h30;
  localparam logic [6:0] RES_BASE  = 7'h40;

  // Index of the last text / result byte
  localparam logic [5:0] LAST_BLOCK_BYTE = 6'd15;

  typedef enum logic [1:0] {
    KEYLEN_128 = 2'd0,
    KEYLEN_192 = 2'd1,
    KEYLEN_256 = 2'd2
  } keylen_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CFG,
    ST_KEY,
    ST_TEXT,
    ST_GO,
    ST_WAIT,
    ST_RD,
    ST_RESP
  } state_e;

  // The reserved encoding 3 is folded onto 256-bit so it behaves identically.
  function automatic keylen_e norm_keylen(input logic [1:0] kl);
    case (kl)
      2'd0:    return KEYLEN_128;
      2'd1:    return KEYLEN_192;
      default: return KEYLEN_256;
    endcase
  endfunction

  function automatic logic [5:0] key_bytes(input keylen_e kl);
    case (kl)
      KEYLEN_128: return 6'd16;
      KEYLEN_192: return 6'd24;
      default:    return 6'd32;
    endcase
  endfunction

endpackage

// File: rtl/aes_host_driver_if.sv
// rtl/aes_host_driver_if.sv - requester channel and AES host pin bundle
//
// Purpose: groups the request/response handshake and the byte-wide AES host
//          bus into one interface.
// Modports:
//   master - the driver: accepts requests, returns responses, drives DIN/ADDR/WR/START,
//            reads OK/DOUT.
//   slave  - the environment: requester plus AES host port.

interface aes_host_driver_if;

  // Requester side
  logic         req_valid;
  logic         req_ready;
  logic [127:0] req_text;
  logic [255:0] req_key;
  logic [1:0]   req_keylen;
  logic         req_op;
  logic         req_key_skip;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [127:0] rsp_data;
  logic         rsp_err;

  // AES host pins
  logic [7:0]   DIN;
  logic [6:0]   ADDR;
  logic         WR;
  logic         START;
  logic         OK;
  logic [7:0]   DOUT;

  modport master (
    input  req_valid, req_text, req_key, req_keylen, req_op, req_key_skip, rsp_ready,
    input  OK, DOUT,
    output req_ready, rsp_valid, rsp_data, rsp_err,
    output DIN, ADDR, WR, START
  );

  modport slave (
    output req_valid, req_text, req_key, req_keylen, req_op, req_key_skip, rsp_ready,
    output OK, DOUT,
    input  req_ready, rsp_valid, rsp_data, rsp_err,
    input  DIN, ADDR, WR, START
  );

endinterface

// File: rtl/aes_host_driver.sv
// rtl/aes_host_driver.sv - bus master that runs one AES block through the byte-wide host port
//
// Purpose: latches a request (text, key, keylen, op, key_skip), writes config,
//          key and text bytes over DIN/ADDR/WR, pulses START, waits for OK
//          (bounded by TIMEOUT), reads 16 result bytes over DOUT and returns
//          them on the response channel.
// Ports:
//   CLK   - system clock
//   RSTB  - synchronous active-low reset
//   bus   - aes_host_driver_if.master: req_*/rsp_* channel and DIN/ADDR/WR/START/OK/DOUT
// Parameters:
//   READ_LAT - cycles from a read ADDR to valid DOUT (1..3)
//   TIMEOUT  - maximum WAIT cycles before aborting with rsp_err

module aes_host_driver
  import aes_host_pkg::*;
#(
  parameter int READ_LAT = 1,
  parameter int TIMEOUT  = 4096
) (
  input logic               CLK,
  input logic               RSTB,
  aes_host_driver_if.master bus
);

  localparam int              WAIT_W   = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);
  localparam logic [1:0]      LAT_LAST = 2'(READ_LAT);

  state_e              r_state, w_state;
  logic [5:0]          r_idx, w_idx;
  logic [WAIT_W-1:0]   r_wait, w_wait, w_wait_inc;
  logic [1:0]          r_lat, w_lat;
  logic [127:0]        r_text, w_text;
  logic [255:0]        r_key, w_key;
  keylen_e             r_keylen, w_keylen, w_kl_in;
  logic                r_op, w_op;
  logic                r_skip, w_skip;
  logic [127:0]        r_res, w_res;
  logic [7:0]          r_din, w_din;
  logic [6:0]          r_addr, w_addr;
  logic                r_wr, w_wr;
  logic                r_start, w_start;
  logic                r_rsp_valid, w_rsp_valid;
  logic                r_rsp_err, w_rsp_err;

  assign w_kl_in = norm_keylen(bus.req_keylen);

  // Next-state and next-output logic. Host outputs are registered, so every
  // branch computes what the pins must show during the state being entered.
  // Key and text registers shift left one byte per write so the byte to send
  // is always in the top 8 bits.
  always_comb begin
    w_state     = r_state;
    w_idx       = r_idx;
    w_wait      = r_wait;
    w_lat       = r_lat;
    w_text      = r_text;
    w_key       = r_key;
    w_keylen    = r_keylen;
    w_op        = r_op;
    w_skip      = r_skip;
    w_res       = r_res;
    w_din       = r_din;
    w_addr      = r_addr;
    w_wr        = 1'b0;
    w_start     = 1'b0;
    w_rsp_valid = r_rsp_valid;
    w_rsp_err   = r_rsp_err;
    w_wait_inc  = (r_wait == WAIT_MAX) ? r_wait : r_wait + 1'b1;

    unique case (r_state)
      ST_IDLE: begin
        if (bus.req_valid) begin
          w_state   = ST_CFG;
          w_text    = bus.req_text;
          w_key     = bus.req_key;
          w_keylen  = w_kl_in;
          w_op      = bus.req_op;
          w_skip    = bus.req_key_skip;
          w_res     = '0;
          w_rsp_err = 1'b0;
          w_wr      = 1'b1;
          w_addr    = CFG_ADDR;
          w_din     = {5'b0, bus.req_op, w_kl_in};
        end
      end

      ST_CFG: begin
        w_idx = '0;
        w_wr  = 1'b1;
        if (r_skip) begin
          w_state = ST_TEXT;
          w_addr  = TEXT_BASE;
          w_din   = r_text[127:120];
          w_text  = {r_text[119:0], 8'h00};
        end else begin
          w_state = ST_KEY;
          w_addr  = KEY_BASE;
          w_din   = r_key[255:248];
          w_key   = {r_key[247:0], 8'h00};
        end
      end

      ST_KEY: begin
        w_wr = 1'b1;
        if (r_idx == key_bytes(r_keylen) - 6'd1) begin
          w_state = ST_TEXT;
          w_idx   = '0;
          w_addr  = TEXT_BASE;
          w_din   = r_text[127:120];
          w_text  = {r_text[119:0], 8'h00};
        end else begin
          w_idx  = r_idx + 6'd1;
          w_addr = KEY_BASE + ({1'b0, r_idx} + 7'd1);
          w_din  = r_key[255:248];
          w_key  = {r_key[247:0], 8'h00};
        end
      end

      ST_TEXT: begin
        if (r_idx == LAST_BLOCK_BYTE) begin
          w_state = ST_GO;
          w_start = 1'b1;
        end else begin
          w_wr   = 1'b1;
          w_idx  = r_idx + 6'd1;
          w_addr = TEXT_BASE + ({1'b0, r_idx} + 7'd1);
          w_din  = r_text[127:120];
          w_text = {r_text[119:0], 8'h00};
        end
      end

      ST_GO: begin
        w_state = ST_WAIT;
        w_wait  = '0;
      end

      // OK has priority over a timeout landing on the same cycle.
      ST_WAIT: begin
        if (bus.OK) begin
          w_state = ST_RD;
          w_idx   = '0;
          w_lat   = '0;
          w_addr  = RES_BASE;
        end else begin
          w_wait = w_wait_inc;
          if (w_wait_inc == WAIT_MAX) begin
            w_state     = ST_RESP;
            w_rsp_valid = 1'b1;
            w_rsp_err   = 1'b1;
            w_res       = '0;
          end
        end
      end

      // One byte per 1+READ_LAT cycles: ADDR held, DOUT captured when the
      // latency counter reaches READ_LAT, then the next address goes out.
      ST_RD: begin
        if (r_lat == LAT_LAST) begin
          w_res = {r_res[119:0], bus.DOUT};
          w_lat = '0;
          if (r_idx == LAST_BLOCK_BYTE) begin
            w_state     = ST_RESP;
            w_rsp_valid = 1'b1;
            w_rsp_err   = 1'b0;
          end else begin
            w_idx  = r_idx + 6'd1;
            w_addr = RES_BASE + ({1'b0, r_idx} + 7'd1);
          end
        end else begin
          w_lat = r_lat + 2'd1;
        end
      end

      ST_RESP: begin
        if (bus.rsp_ready) begin
          w_state     = ST_IDLE;
          w_rsp_valid = 1'b0;
        end
      end

      default: begin
        w_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTB) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_wait      <= '0;
      r_lat       <= '0;
      r_text      <= '0;
      r_key       <= '0;
      r_keylen    <= KEYLEN_128;
      r_op        <= 1'b0;
      r_skip      <= 1'b0;
      r_res       <= '0;
      r_din       <= '0;
      r_addr      <= '0;
      r_wr        <= 1'b0;
      r_start     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_idx       <= w_idx;
      r_wait      <= w_wait;
      r_lat       <= w_lat;
      r_text      <= w_text;
      r_key       <= w_key;
      r_keylen    <= w_keylen;
      r_op        <= w_op;
      r_skip      <= w_skip;
      r_res       <= w_res;
      r_din       <= w_din;
      r_addr      <= w_addr;
      r_wr        <= w_wr;
      r_start     <= w_start;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_err   <= w_rsp_err;
    end
  end

  assign bus.req_ready = (r_state == ST_IDLE);
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_res;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.DIN       = r_din;
  assign bus.ADDR      = r_addr;
  assign bus.WR        = r_wr;
  assign bus.START     = r_start;

endmodule
